// File: rtl/keypad_scanner_if.sv
// Keypad scanner bundle: matrix lines plus the decoded key outputs.
//   row_in        : matrix row lines, active-low, asynchronous to clk
//   col_out       : column drive, active-low, one-cold
//   keypad_input  : note code of the accepted key (1..8, 0 for function keys)
//   keypad_enable : high while an accepted key is held
//   key_index     : raw key number row*4+col of the last accepted key
//   key_press     : one-cycle pulse on press acceptance
//   key_release   : one-cycle pulse on release acceptance
//   multi_key     : one-cycle pulse when several rows are low in one column
// master = scanner side, slave = matrix / consumer side.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] keypad_input;
  logic       keypad_enable;
  logic [3:0] key_index;
  logic       key_press;
  logic       key_release;
  logic       multi_key;

  modport master (
    input  row_in,
    output col_out, keypad_input, keypad_enable, key_index,
           key_press, key_release, multi_key
  );

  modport slave (
    output row_in,
    input  col_out, keypad_input, keypad_enable, key_index,
           key_press, key_release, multi_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debouncing.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high, clears all state
//   kp    : keypad_scanner_if.master (row_in in; col_out and key outputs out)
// Parameters:
//   SCAN_DIV     : clocks per column dwell / sample period (>= 4)
//   DEBOUNCE_CNT : consecutive matching samples to accept press or release (>= 2)
module keypad_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  // A match seen while the count already holds this value completes the run.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    REL_DEBOUNCE
  } state_t;

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    col_drive = ~(4'b0001 << c);
  endfunction

  function automatic logic [3:0] note_of(input logic [3:0] idx);
    note_of = idx[3] ? 4'd0 : idx + 4'd1;
  endfunction

  state_t           state;
  logic [3:0]       row_p0;
  logic [3:0]       row_p1;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       col;
  logic [1:0]       cap_row;
  logic [3:0]       col_out;
  logic [3:0]       keypad_input;
  logic             keypad_enable;
  logic [3:0]       key_index;
  logic             key_press;
  logic             key_release;
  logic             multi_key;

  logic             sample;
  logic [2:0]       low_cnt;
  logic [1:0]       low_row;
  logic [1:0]       col_next;
  logic             single_low;
  logic             multi_low;
  logic             match;
  logic             cap_high;

  // Stage p0/p1: two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_p0 <= 4'b1111;
      row_p1 <= 4'b1111;
    end else begin
      row_p0 <= kp.row_in;
      row_p1 <= row_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign sample = (div == DIV_LAST);

  // Count the low rows and find the lowest-numbered one.
  always_comb begin
    low_cnt = 3'd0;
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_p1[i]) begin
        low_cnt = low_cnt + 3'd1;
        low_row = i[1:0];
      end
    end
  end

  assign col_next   = col + 2'd1;
  assign single_low = (low_cnt == 3'd1);
  assign multi_low  = (low_cnt >= 3'd2);
  assign match      = single_low && (low_row == cap_row);
  assign cap_high   = row_p1[cap_row];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= SCAN;
      cnt           <= '0;
      col           <= 2'd0;
      cap_row       <= 2'd0;
      col_out       <= 4'b1110;
      keypad_input  <= 4'd0;
      keypad_enable <= 1'b0;
      key_index     <= 4'd0;
      key_press     <= 1'b0;
      key_release   <= 1'b0;
      multi_key     <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      multi_key   <= 1'b0;
      if (sample) begin
        unique case (state)
          SCAN: begin
            if (single_low) begin
              // Freeze the column on the key and start counting matches.
              cap_row <= low_row;
              cnt     <= CNT_W'(1);
              state   <= DEBOUNCE;
            end else begin
              if (multi_low) begin
                multi_key <= 1'b1;
                cnt       <= '0;
              end
              col     <= col_next;
              col_out <= col_drive(col_next);
            end
          end
          DEBOUNCE: begin
            if (multi_low) begin
              multi_key <= 1'b1;
              cnt       <= '0;
              state     <= SCAN;
              col       <= col_next;
              col_out   <= col_drive(col_next);
            end else if (match) begin
              if (cnt == CNT_LAST) begin
                state         <= HELD;
                cnt           <= '0;
                keypad_enable <= 1'b1;
                key_press     <= 1'b1;
                key_index     <= {cap_row, col};
                keypad_input  <= note_of({cap_row, col});
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              // Bounce or early release: resume scanning from this column.
              cnt   <= '0;
              state <= SCAN;
            end
          end
          HELD: begin
            // Only the captured row matters; other rows are ignored here.
            if (cap_high) begin
              cnt   <= CNT_W'(1);
              state <= REL_DEBOUNCE;
            end
          end
          REL_DEBOUNCE: begin
            if (cap_high) begin
              if (cnt == CNT_LAST) begin
                state         <= SCAN;
                cnt           <= '0;
                keypad_enable <= 1'b0;
                key_release   <= 1'b1;
                col           <= col_next;
                col_out       <= col_drive(col_next);
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              cnt   <= '0;
              state <= HELD;
            end
          end
          default: begin
            state <= SCAN;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign kp.col_out       = col_out;
  assign kp.keypad_input  = keypad_input;
  assign kp.keypad_enable = keypad_enable;
  assign kp.key_index     = key_index;
  assign kp.key_press     = key_press;
  assign kp.key_release   = key_release;
  assign kp.multi_key     = multi_key;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical 4x4 matrix model driven by the DUT's
// column output, directed and randomized key activity, and a sample-level
// behavioural model compared against every output on every cycle.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 3;

  localparam int M_SCAN = 0;
  localparam int M_DEB  = 1;
  localparam int M_HELD = 2;
  localparam int M_REL  = 3;

  logic clk;
  logic reset;
  logic [15:0] pressed;

  int total;
  int bad;
  int n_press;
  int n_rel;
  int n_multi;

  // Reference model state
  logic [3:0] m_hist [2];
  int m_n;
  int m_mode;
  int m_col;
  int m_row;
  int m_cnt;
  int m_en;
  int m_idx;
  int m_note;
  int m_press;
  int m_rel;
  int m_multi;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Row r is pulled low when a held key in row r sits on the driven column.
  function automatic logic [3:0] matrix(input logic [15:0] p, input logic [3:0] co);
    logic [3:0] r;
    r = 4'b1111;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (p[ri*4+ci] && !co[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    m_hist[0] = 4'b1111;
    m_hist[1] = 4'b1111;
    m_n = 0; m_mode = M_SCAN; m_col = 0; m_row = 0; m_cnt = 0;
    m_en = 0; m_idx = 0; m_note = 0; m_press = 0; m_rel = 0; m_multi = 0;
  endtask

  task automatic model_edge(input logic [3:0] ri);
    logic [3:0] rs;
    int nlow;
    int lrow;
    bit smp;
    rs = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = ri;
    smp = ((m_n % SD) == SD - 1);
    m_n++;
    m_press = 0; m_rel = 0; m_multi = 0;
    if (!smp) return;
    nlow = 0; lrow = 0;
    for (int r = 0; r < 4; r++)
      if (!rs[r]) begin
        if (nlow == 0) lrow = r;
        nlow++;
      end
    case (m_mode)
      M_SCAN: begin
        if (nlow == 1) begin
          m_row = lrow; m_cnt = 1; m_mode = M_DEB;
        end else begin
          if (nlow >= 2) begin m_multi = 1; m_cnt = 0; end
          m_col = (m_col + 1) % 4;
        end
      end
      M_DEB: begin
        if (nlow >= 2) begin
          m_multi = 1; m_cnt = 0; m_mode = M_SCAN; m_col = (m_col + 1) % 4;
        end else if (nlow == 1 && lrow == m_row) begin
          m_cnt++;
          if (m_cnt == DC) begin
            m_mode = M_HELD; m_cnt = 0; m_en = 1; m_press = 1;
            m_idx = m_row * 4 + m_col;
            m_note = (m_idx < 8) ? m_idx + 1 : 0;
          end
        end else begin
          m_cnt = 0; m_mode = M_SCAN;
        end
      end
      M_HELD: begin
        if (rs[m_row]) begin m_cnt = 1; m_mode = M_REL; end
      end
      default: begin
        if (rs[m_row]) begin
          m_cnt++;
          if (m_cnt == DC) begin
            m_mode = M_SCAN; m_cnt = 0; m_en = 0; m_rel = 1;
            m_col = (m_col + 1) % 4;
          end
        end else begin
          m_cnt = 0; m_mode = M_HELD;
        end
      end
    endcase
  endtask

  task automatic step();
    logic [3:0] ri;
    logic [3:0] ec;
    ri = matrix(pressed, kif.col_out);
    kif.row_in = ri;
    @(posedge clk);
    model_edge(ri);
    #1;
    ec = 4'hF;
    ec[m_col] = 1'b0;
    chk("col_out", kif.col_out, ec);
    chk("enable", kif.keypad_enable, m_en);
    chk("press", kif.key_press, m_press);
    chk("release", kif.key_release, m_rel);
    chk("multi", kif.multi_key, m_multi);
    chk("index", kif.key_index, m_idx);
    chk("note", kif.keypad_input, m_note);
    chk("press_and_release", kif.key_press & kif.key_release, 0);
    n_press += int'(kif.key_press);
    n_rel   += int'(kif.key_release);
    n_multi += int'(kif.multi_key);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int p0;
    int r0;
    int mu0;
    int k;
    total = 0; bad = 0; n_press = 0; n_rel = 0; n_multi = 0;
    pressed = '0;
    kif.row_in = 4'b1111;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", kif.col_out, 4'b1110);
    chk("rst_enable", kif.keypad_enable, 0);
    chk("rst_note", kif.keypad_input, 0);
    chk("rst_index", kif.key_index, 0);
    chk("rst_press", kif.key_press, 0);
    chk("rst_release", kif.key_release, 0);
    chk("rst_multi", kif.multi_key, 0);
    reset = 1'b0;

    // Idle scanning
    steps(32);
    chk("idle_pulses", n_press + n_rel + n_multi, 0);

    // Key 6: row 1, column 2
    p0 = n_press; r0 = n_rel;
    steps($urandom_range(0, 7));
    pressed = 16'h1 << 6;
    steps(40);
    chk("k6_enable", kif.keypad_enable, 1);
    pressed = '0;
    steps(30);
    chk("k6_index", kif.key_index, 6);
    chk("k6_note", kif.keypad_input, 7);
    chk("k6_enable_off", kif.keypad_enable, 0);
    chk("k6_press_cnt", n_press - p0, 1);
    chk("k6_release_cnt", n_rel - r0, 1);

    // Key 13: function key, note 0
    pressed = 16'h1 << 13;
    steps(40);
    chk("k13_index", kif.key_index, 13);
    chk("k13_note", kif.keypad_input, 0);
    chk("k13_enable", kif.keypad_enable, 1);
    pressed = '0;
    steps(30);

    // Bouncing press, then a short release glitch while held
    p0 = n_press; r0 = n_rel;
    for (int b = 0; b < 4; b++) begin
      pressed = 16'h1 << 5;
      steps($urandom_range(4, 6));
      pressed = '0;
      steps($urandom_range(4, 6));
    end
    chk("bounce_no_press", n_press - p0, 0);
    pressed = 16'h1 << 5;
    steps(40);
    chk("bounce_press_cnt", n_press - p0, 1);
    pressed = '0;
    steps($urandom_range(4, 6));
    pressed = 16'h1 << 5;
    steps(20);
    chk("glitch_enable", kif.keypad_enable, 1);
    chk("glitch_no_release", n_rel - r0, 0);
    pressed = '0;
    steps(30);
    chk("bounce_release_cnt", n_rel - r0, 1);

    // Rows 0 and 2 together on column 0
    p0 = n_press; mu0 = n_multi;
    pressed = (16'h1 << 0) | (16'h1 << 8);
    steps(40);
    chk("multi_seen", (n_multi - mu0) > 0, 1);
    chk("multi_no_press", n_press - p0, 0);
    pressed = '0;
    steps(20);

    // Reset while a key is held
    pressed = 16'h1 << 10;
    steps(40);
    chk("pre_rst_enable", kif.keypad_enable, 1);
    r0 = n_rel; p0 = n_press;
    reset = 1'b1;
    #1;
    chk("hrst_enable", kif.keypad_enable, 0);
    chk("hrst_col", kif.col_out, 4'b1110);
    chk("hrst_release", kif.key_release, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    steps(40);
    chk("hrst_repress", n_press - p0, 1);
    chk("hrst_enable_again", kif.keypad_enable, 1);
    chk("hrst_no_release", n_rel - r0, 0);
    pressed = '0;
    steps(30);

    // Randomized key activity
    for (int it = 0; it < 16; it++) begin
      k = $urandom_range(0, 15);
      pressed = 16'h1 << k;
      if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
      steps($urandom_range(0, 50));
      pressed = '0;
      steps($urandom_range(0, 40));
    end
    steps(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: clocks per column dwell / sample period; SHALL be >= 4.
REQ-002 Parameter DEBOUNCE_CNT, default 3: consecutive matching samples needed to accept a press or a release; SHALL be >= 2.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 row_in  in  4  matrix row lines; active-low, externally pulled up; asynchronous to clk.
REQ-006 col_out  out  4  column drive; active-low; exactly one bit low at all times.
REQ-007 keypad_input  out  4  note code of accepted key: 1..8 for note keys, 0 for function keys.
REQ-008 keypad_enable  out  1  level signal, high while an accepted key is held (consumed by the game block).
REQ-009 key_index  out  4  raw key number, row*4+col, of the last accepted key.
REQ-010 key_press  out  1  one-cycle pulse on acceptance of a press.
REQ-011 key_release  out  1  one-cycle pulse on acceptance of a release.
REQ-012 multi_key  out  1  one-cycle pulse when more than one row is low in the driven column.

Function
REQ-013 row_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-014 A dwell counter SHALL count 0..SCAN_DIV-1 and wrap; a "sample" occurs on the cycle where the count equals SCAN_DIV-1.
REQ-015 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, HELD, REL_DEBOUNCE.
REQ-016 In SCAN, at each sample with all rows high, the driven column SHALL advance 0->1->2->3->0, and the new column SHALL be driven on the next cycle.
REQ-017 In SCAN, a sample with exactly one row low SHALL capture that row and column, set the stable count to 1, freeze the column, and enter DEBOUNCE.
REQ-018 In SCAN or DEBOUNCE, a sample with two or more rows low SHALL pulse multi_key, clear the stable count, and return to or remain in SCAN with the column still advancing.
REQ-019 In DEBOUNCE, a sample matching the captured row SHALL increment the stable count; any mismatch, including release, SHALL return to SCAN with the count cleared.
REQ-020 When the stable count reaches DEBOUNCE_CNT, the scanner SHALL on that same edge enter HELD, set keypad_enable=1, pulse key_press, and load key_index and keypad_input.
REQ-021 Press latency SHALL be (DEBOUNCE_CNT-1)*SCAN_DIV clocks from the capture edge to the keypad_enable rise.
REQ-022 keypad_input SHALL equal key_index+1 when key_index<8, and 0 otherwise.
REQ-023 In HELD, the column SHALL stay frozen; a sample with the captured row high SHALL enter REL_DEBOUNCE with the release count set to 1; extra rows going low SHALL be ignored.
REQ-024 In REL_DEBOUNCE, a sample with the row still high SHALL increment the release count; a sample with the row low SHALL return to HELD, with keypad_enable staying 1 throughout.
REQ-025 When the release count reaches DEBOUNCE_CNT, the scanner SHALL set keypad_enable=0, pulse key_release, and return to SCAN with the column advancing from the frozen column +1.
REQ-026 keypad_input and key_index SHALL hold their values after release until the next accepted press.
REQ-027 key_press and key_release SHALL never be asserted in the same cycle, and each SHALL occur at most once per physical press.

Reset
REQ-028 On reset: state=SCAN, col_out=4'b1110, dwell count=0, stable and release counts=0, synchronizer=4'b1111, keypad_input=0, key_index=0, keypad_enable=0, key_press=0, key_release=0, multi_key=0.
REQ-029 Reset asserted in any state, including HELD, SHALL drop keypad_enable within the same cycle with no key_release pulse; after deassertion, scanning SHALL restart at column 0.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-030 Idle rows 4'b1111 for 32 cycles -> col_out cycles 1110,1101,1011,0111 with 4 clk each; no pulses.
REQ-031 Row 1 held low while column 2 is driven -> key_index=6, keypad_input=7, single key_press, keypad_enable rises 8 clk after capture; release held 12 clk -> key_release, keypad_enable=0, keypad_input stays 7.
REQ-032 Row 3 low at column 1 -> key_index=13, keypad_input=0, keypad_enable=1.
REQ-033 Press bouncing low-high-low across samples in DEBOUNCE -> no key_press until 3 consecutive matching samples; release glitch of 1 sample in HELD -> keypad_enable stays 1, no key_release.
REQ-034 Rows 0 and 2 low together at column 0 -> multi_key pulse, no key_press, scanning continues.
REQ-035 Reset pulsed while in HELD -> keypad_enable=0 immediately, col_out=1110, no key_release; key still held -> re-accepted with a fresh key_press.
